// File: rtl/hdmi_period_scheduler.sv
// TMDS period scheduler: delays sync/DE/RGB by LEAD clocks and emits mode/CTL so that
// each active-video run is preceded by a preamble and guard band. Feature macro: HDMI_GUARD_BAND_EN.
module hdmi_period_scheduler #(
   parameter int PREAMBLE_LEN = 8,
   parameter int GUARD_LEN    = 2
) (
   input  logic       clk_pixel,
   input  logic       rst,
   input  logic       in_hsync,
   input  logic       in_vsync,
   input  logic       in_de,
   input  logic [7:0] in_red,
   input  logic [7:0] in_green,
   input  logic [7:0] in_blue,
   output logic       out_hsync,
   output logic       out_vsync,
   output logic       out_de,
   output logic [7:0] out_red,
   output logic [7:0] out_green,
   output logic [7:0] out_blue,
   output logic [1:0] mode,
   output logic [3:0] ctl,
   output logic       sched_err
);

   localparam int LEAD   = PREAMBLE_LEN + GUARD_LEN;
   localparam int W      = 27;
   localparam int DE_BIT = 24;

   localparam logic [1:0] MODE_CONTROL  = 2'd0;
   localparam logic [1:0] MODE_PREAMBLE = 2'd1;
   localparam logic [1:0] MODE_GUARD    = 2'd2;
   localparam logic [1:0] MODE_VIDEO    = 2'd3;

   // Stage 0 doubles as in_de_q; stage LEAD drives the out_* ports.
   logic [LEAD:0][W-1:0] pipe_q;
   logic                 feed_de;

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= {pipe_q[LEAD-1:0],
                    {in_hsync, in_vsync, in_de, in_red, in_green, in_blue}};
      end
   end

   assign {out_hsync, out_vsync, out_de, out_red, out_green, out_blue} = pipe_q[LEAD];
   assign feed_de = pipe_q[LEAD-1][DE_BIT];

   logic [1:0] mode_d;
   logic [3:0] ctl_d;
   logic       sched_err_d;
   logic [1:0] mode_q;
   logic [3:0] ctl_q;
   logic       sched_err_q;

`ifdef HDMI_GUARD_BAND_EN
   typedef enum logic [1:0] {
      ST_CONTROL  = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_GUARD    = 2'd2,
      ST_VIDEO    = 2'd3
   } state_t;

   localparam logic [3:0] PRE_LOAD   = 4'(PREAMBLE_LEN - 1);
   localparam logic [3:0] GUARD_LOAD = 4'(GUARD_LEN - 1);

   state_t     state_q;
   state_t     state_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic       rise;
   logic       accept;

   assign rise = in_de & ~pipe_q[0][DE_BIT];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      // A rise is usable only when no sequence is running and the previous run is ending.
      accept      = rise & ((state_q == ST_CONTROL) | ((state_q == ST_VIDEO) & ~feed_de));
      sched_err_d = rise & ~accept;
      case (state_q)
         ST_CONTROL: begin
            if (accept) begin
               state_d = ST_PREAMBLE;
               cnt_d   = PRE_LOAD;
            end else if (feed_de) begin
               state_d = ST_VIDEO;
            end
         end
         ST_PREAMBLE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_GUARD;
               cnt_d   = GUARD_LOAD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_GUARD: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_VIDEO;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            if (accept) begin
               state_d = ST_PREAMBLE;
               cnt_d   = PRE_LOAD;
            end else if (!feed_de) begin
               state_d = ST_CONTROL;
            end
         end
      endcase

      if (feed_de) begin
         mode_d = MODE_VIDEO;
      end else if (state_d == ST_PREAMBLE) begin
         mode_d = MODE_PREAMBLE;
      end else if (state_d == ST_GUARD) begin
         mode_d = MODE_GUARD;
      end else begin
         mode_d = MODE_CONTROL;
      end
      ctl_d = (mode_d == MODE_PREAMBLE) ? 4'b0001 : 4'b0000;
   end
`else
   always_comb begin
      mode_d      = feed_de ? MODE_VIDEO : MODE_CONTROL;
      ctl_d       = 4'b0000;
      sched_err_d = 1'b0;
   end
`endif

   always_ff @(posedge clk_pixel or posedge rst) begin
      if (rst) begin
`ifdef HDMI_GUARD_BAND_EN
         state_q <= ST_CONTROL;
         cnt_q   <= 4'd0;
`endif
         mode_q      <= MODE_CONTROL;
         ctl_q       <= 4'b0000;
         sched_err_q <= 1'b0;
      end else begin
`ifdef HDMI_GUARD_BAND_EN
         state_q <= state_d;
         cnt_q   <= cnt_d;
`endif
         mode_q      <= mode_d;
         ctl_q       <= ctl_d;
         sched_err_q <= sched_err_d;
      end
   end

   assign mode      = mode_q;
   assign ctl       = ctl_q;
   assign sched_err = sched_err_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Bench for hdmi_period_scheduler: directed lines/gaps/resets with an edge-history reference model
// checked every cycle, plus hand-computed literal checks. Honours HDMI_GUARD_BAND_EN like the design.
module tb_hdmi_period_scheduler;

   localparam int PL   = 8;
   localparam int GL   = 2;
   localparam int LEAD = PL + GL;
`ifdef HDMI_GUARD_BAND_EN
   localparam bit HDMI = 1'b1;
`else
   localparam bit HDMI = 1'b0;
`endif

   logic       clk_pixel = 1'b0;
   logic       rst = 1'b1;
   logic       in_hsync = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
   logic [7:0] in_red = '0, in_green = '0, in_blue = '0;
   logic       out_hsync, out_vsync, out_de;
   logic [7:0] out_red, out_green, out_blue;
   logic [1:0] mode;
   logic [3:0] ctl;
   logic       sched_err;

   always #5 clk_pixel = ~clk_pixel;

   hdmi_period_scheduler #(.PREAMBLE_LEN(PL), .GUARD_LEN(GL)) dut (
      .clk_pixel(clk_pixel), .rst(rst),
      .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
      .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
      .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de),
      .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
      .mode(mode), .ctl(ctl), .sched_err(sched_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
      end
   endtask

   // Reference model: history of sampled inputs indexed by age in edges (0 = this edge).
   logic [26:0] hist [0:LEAD+1];
   int          edge_n   = 0;
   int          last_acc = -1000;
   logic [26:0] exp_out  = '0;
   logic [1:0]  exp_mode = '0;
   logic [3:0]  exp_ctl  = '0;
   logic        exp_err  = 1'b0;

   task automatic model_step();
      bit rise, busy, accept;
      int since;
      if (rst) begin
         for (int i = 0; i <= LEAD + 1; i++) hist[i] = '0;
         last_acc = -1000;
         exp_out  = '0;
         exp_mode = 2'd0;
         exp_ctl  = 4'd0;
         exp_err  = 1'b0;
      end else begin
         edge_n++;
         for (int i = LEAD + 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = {in_hsync, in_vsync, in_de, in_red, in_green, in_blue};
         rise   = hist[0][24] && !hist[1][24];
         // Busy while a preamble+guard is still being emitted; blocked while output video continues.
         busy   = (edge_n - last_acc) < LEAD;
         accept = rise && !busy && !(hist[LEAD+1][24] && hist[LEAD][24]);
         if (accept) last_acc = edge_n;
         since   = edge_n - last_acc;
         exp_out = hist[LEAD];
         if (hist[LEAD][24])             exp_mode = 2'd3;
         else if (HDMI && since < PL)    exp_mode = 2'd1;
         else if (HDMI && since < LEAD)  exp_mode = 2'd2;
         else                            exp_mode = 2'd0;
         exp_ctl = (exp_mode == 2'd1) ? 4'd1 : 4'd0;
         exp_err = HDMI && rise && !accept;
      end
   endtask

   always @(posedge clk_pixel) model_step();

   always @(negedge clk_pixel) begin
      if (rst)
         check("reset_outputs",
               {out_hsync, out_vsync, out_de, out_red, out_green, out_blue, mode, ctl, sched_err},
               64'd0);
      else
         check("cycle_model",
               {out_hsync, out_vsync, out_de, out_red, out_green, out_blue, mode, ctl, sched_err},
               {exp_out, exp_mode, exp_ctl, exp_err});
   end

   task automatic step(input logic hs, input logic vs, input logic de, input logic [23:0] rgb);
      in_hsync = hs;
      in_vsync = vs;
      in_de    = de;
      {in_red, in_green, in_blue} = rgb;
      @(negedge clk_pixel);
   endtask

   function automatic logic [23:0] pix(input int ln, input int c);
      if (ln == 0 && c == 20) return 24'h112233;
      return {8'(ln + 64), 8'(c), 8'(c >> 8) ^ 8'hA5};
   endfunction

   task automatic run_line(input int ln);
      for (int c = 0; c < 858; c++) begin
         step(c >= 700 && c < 762, ln == 1, c >= 20 && c < 660, pix(ln, c));
         if (ln == 0) begin
            if (c >= 20 && c <= 27) begin
               check("nominal_pre_mode", mode, HDMI ? 2'd1 : 2'd0);
               check("nominal_pre_ctl", ctl, HDMI ? 4'd1 : 4'd0);
            end
            if (c == 28 || c == 29) begin
               check("nominal_guard_mode", mode, HDMI ? 2'd2 : 2'd0);
               check("nominal_guard_ctl", ctl, 4'd0);
            end
            if (c == 30) begin
               check("nominal_video_mode", mode, 2'd3);
               check("nominal_video_de", out_de, 1'b1);
               check("nominal_first_rgb", {out_red, out_green, out_blue}, 24'h112233);
            end
            if (c == 669) check("eol_last_video", {out_de, mode}, 3'b1_11);
            if (c == 670) check("eol_control", {out_de, mode}, 3'b0_00);
            if (c == 709) check("hsync_delay_low", out_hsync, 1'b0);
            if (c == 710) check("hsync_delay_rise", out_hsync, 1'b1);
            if (c == 771) check("hsync_delay_last", out_hsync, 1'b1);
            if (c == 772) check("hsync_delay_fall", out_hsync, 1'b0);
         end
      end
   endtask

   initial begin
      // Reset held with random inputs.
      for (int i = 0; i < 6; i++) begin
         step(1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom));
         check("rst_hold_outputs",
               {out_hsync, out_vsync, out_de, out_red, out_green, out_blue, mode, ctl, sched_err},
               64'd0);
      end
      step(1'b0, 1'b0, 1'b0, 24'd0);
      rst = 1'b0;

      for (int ln = 0; ln < 4; ln++) run_line(ln);

      // Short gap: 40 high, 4 low, 40 high.
      for (int s = 0; s < 114; s++) begin
         step(1'b0, 1'b0, (s < 40) || (s >= 44 && s < 84), 24'($urandom));
         if (s == 10) check("gap_run1_video", mode, 2'd3);
         if (s == 44) begin
            check("gap_err_pulse", sched_err, HDMI);
            check("gap_mode_at_rise", mode, 2'd3);
         end
         if (s == 45) check("gap_err_clear", sched_err, 1'b0);
         if (s == 50) check("gap_no_preamble", {out_de, mode}, 3'b0_00);
         if (s == 54) check("gap_run2_video", {out_de, mode}, 3'b1_11);
      end

      // One-pixel run, then a rise on the edge where out_de falls.
      for (int s = 0; s < 46; s++) begin
         step(1'b0, 1'b0, (s == 0) || (s >= 11 && s < 16), 24'($urandom));
         if (s == 0)  check("single_pre", mode, HDMI ? 2'd1 : 2'd0);
         if (s == 10) check("single_video", {out_de, mode}, 3'b1_11);
         if (s == 11) check("simul_pre", {out_de, mode, sched_err}, {1'b0, HDMI ? 2'd1 : 2'd0, 1'b0});
         if (s == 21) check("simul_video", {out_de, mode}, 3'b1_11);
      end

      // Reset in the middle of a preamble; DE still high at release.
      for (int s = 0; s < 24; s++) step(1'b0, 1'b0, s >= 20, 24'h334455);
      #2 rst = 1'b1;
      #1 check("rst_mid_pre", {mode, ctl, out_de}, 7'd0);
      @(negedge clk_pixel);
      rst = 1'b0;
      for (int r = 0; r < 50; r++) begin
         step(1'b0, 1'b0, r < 20, (r == 0) ? 24'hABCDEF : 24'($urandom));
         if (r == 0) check("rerise_pre", {mode, ctl}, HDMI ? 6'b01_0001 : 6'd0);
         if (r == 8) check("rerise_guard", mode, HDMI ? 2'd2 : 2'd0);
         if (r == 10) check("rerise_video", {out_de, mode, out_red, out_green, out_blue},
                            {1'b1, 2'd3, 24'hABCDEF});
      end

      // Reset in the middle of active video.
      for (int s = 0; s < 26; s++) step(1'b0, 1'b1, s >= 5, 24'($urandom));
      check("pre_rst_video", mode, 2'd3);
      #2 rst = 1'b1;
      #1 check("rst_mid_video",
               {out_hsync, out_vsync, out_de, out_red, out_green, out_blue, mode, ctl, sched_err},
               64'd0);
      @(negedge clk_pixel);
      rst = 1'b0;
      for (int s = 0; s < 30; s++) step(1'b0, 1'b0, 1'b0, 24'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Sequences TMDS period types for the HDMI transmit path: control, video preamble, video guard band and video data.
- Sits between the timing generator / pixel source and the three TMDS encoders.
- Delays sync, DE and RGB by a fixed lookahead so the preamble and guard band can be inserted before each active-video run.
- Drives per-cycle mode select and CTL[3:0] so the encoders and the control-symbol mux emit HDMI-compliant period boundaries.

Parameters:
- PREAMBLE_LEN, 8, preamble length in pixel clocks (legal range 1..15).
- GUARD_LEN, 2, video guard band length in pixel clocks (legal range 1..3).
- Derived localparam: LEAD = PREAMBLE_LEN + GUARD_LEN, the pipeline depth.

Ports:
- clk_pixel  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- in_hsync  in  1  hsync from the timing generator.
- in_vsync  in  1  vsync from the timing generator.
- in_de  in  1  video_active from the timing generator.
- in_red  in  8  pixel red component.
- in_green  in  8  pixel green component.
- in_blue  in  8  pixel blue component.
- out_hsync  out  1  in_hsync delayed by LEAD; feeds ch0 c0.
- out_vsync  out  1  in_vsync delayed by LEAD; feeds ch0 c1.
- out_de  out  1  in_de delayed by LEAD.
- out_red  out  8  in_red delayed by LEAD.
- out_green  out  8  in_green delayed by LEAD.
- out_blue  out  8  in_blue delayed by LEAD.
- mode  out  2  period select: 0 CONTROL, 1 PREAMBLE, 2 GUARD, 3 VIDEO.
- ctl  out  4  CTL3..CTL0; ch1 takes {CTL1,CTL0}, ch2 takes {CTL3,CTL2}.
- sched_err  out  1  one-cycle pulse flagging a DE gap too short for preamble plus guard.

Behaviour:
- Reset (rst is asynchronous, active-high):
  - All outputs go to 0; mode=0 (CONTROL), ctl=0, sched_err=0.
  - The delay pipeline clears to zeros, and the FSM goes to CONTROL with its counter at 0.
  - Reset asserted mid-operation aborts any sequence in progress immediately.
- Delay pipeline:
  - A LEAD-stage register chain carries {hsync, vsync, de, r, g, b}.
  - A value sampled at edge k appears on the out_* ports after edge k+LEAD.
  - No bubbles and no stalls.
- Rise detection: rise = in_de & ~in_de_q, where in_de_q is in_de registered one cycle.
- FSM states and transitions (state and counter registered):
  - CONTROL -> PREAMBLE when rise is seen at edge k; mode=1 after edge k. Counter loads PREAMBLE_LEN-1.
  - PREAMBLE -> GUARD when the counter reaches 0, i.e. after PREAMBLE_LEN cycles (edges k..k+PREAMBLE_LEN-1). Counter loads GUARD_LEN-1.
  - GUARD -> VIDEO when the counter reaches 0. VIDEO begins after edge k+LEAD, coincident with out_de rising.
  - VIDEO -> CONTROL on the same edge out_de goes to 0.
- mode priority: if the pipeline stage feeding out_de is 1, the next mode is VIDEO regardless of FSM state. mode and out_de are therefore always cycle-aligned.
- ctl: 4'b0001 (video preamble: CTL0=1) while mode=1; 4'b0000 in every other mode.
- Short gap (rise seen while the FSM is not in CONTROL):
  - The rise is ignored and sched_err pulses for exactly one cycle after that edge.
  - No preamble or guard band is generated for that run; the data still passes through as VIDEO via out_de priority.
- Timing edge cases:
  - DE runs of length 1 are legal.
  - A DE rise on the first cycle after reset release is legal; in_de_q resets to 0.
- Simultaneous events: out_de falling and a new rise on the same edge → mode goes to PREAMBLE, provided the FSM is in VIDEO or CONTROL.
- Counters saturate at 0 and never wrap.

Optional Feature:
- Macro: HDMI_GUARD_BAND_EN.
- Defined (HDMI mode):
  - Full behaviour as above.
- Undefined (DVI mode):
  - The FSM is reduced to CONTROL/VIDEO; mode takes only the values 0 and 3.
  - ctl is constant 0, and sched_err is constant 0.
  - Pipeline latency stays LEAD, so data alignment is identical in both builds.

Test Plan:
- Reset: hold rst with random inputs → all outputs 0, mode=0. Assert rst mid-VIDEO → outputs 0 immediately, without waiting for a clock edge.
- Nominal line (defaults, LEAD=10): in_de rises at edge 20 with first pixel RGB=0x112233 → mode=1 and ctl=0001 after edges 20..27; mode=2 and ctl=0 after edges 28..29; mode=3, out_de=1 and out RGB=0x112233 after edge 30.
- End of line: in_de falls at edge 660 → out_de=0 and mode=0 after edge 670; out_hsync/out_vsync equal the inputs delayed by exactly 10 cycles across a full 858x525 frame.
- Short gap: DE high 40 cycles, low 4, high again → sched_err high for one cycle after the second rise edge; no mode=1 or 2 for the second run; mode=3 exactly when out_de=1.
- Reset mid-preamble: rst pulsed after edge 23 of the nominal case → mode=0 and ctl=0 immediately; the next rise after release produces the full 8+2 sequence.
- HDMI_GUARD_BAND_EN undefined: nominal line → mode=0 until edge 30, then 3; ctl and sched_err stay 0 throughout; data identical to the HDMI build.
